// File: rtl/spi_reg_arbiter.sv
// Register-bus controller sharing one bus between SPI slave events and a local requester; event to bus_req in 2 edges, done on ack or TMO_CYC-cycle timeout.
// No backpressure: one SPI event is held (a newer one overwrites it); define LOC_FAIR_EN for alternating SPI/local priority.
module spi_reg_arbiter #(
    parameter int payload = 8,
    parameter int addrsz  = 7,
    parameter int TMO_CYC = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [addrsz-1:0]  spi_addr,
    input  logic               spi_addr_dv,
    input  logic               spi_rw,
    input  logic [payload-1:0] spi_rx_d,
    input  logic               spi_rxdv,
    output logic [payload-1:0] spi_tx_d,
    output logic               spi_tx_en,
    input  logic               loc_req,
    input  logic               loc_we,
    input  logic [addrsz-1:0]  loc_addr,
    input  logic [payload-1:0] loc_wdata,
    output logic               loc_done,
    output logic [payload-1:0] loc_rdata,
    output logic               bus_req,
    output logic               bus_we,
    output logic [addrsz-1:0]  bus_addr,
    output logic [payload-1:0] bus_wdata,
    input  logic               bus_ack,
    input  logic [payload-1:0] bus_rdata,
    output logic               tmo_err
);
    typedef enum logic [1:0] {IDLE, SPI_ACC, LOC_ACC} state_t;

    localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    state_t             state;
    logic               addr_dv_q;
    logic               rxdv_q;
    logic               spi_pend;
    logic               cap_rw;
    logic [addrsz-1:0]  cap_addr;
    logic [payload-1:0] cap_data;
    logic [TW-1:0]      timer;
`ifdef LOC_FAIR_EN
    logic               last_spi;
`endif

    logic spi_evt;
    logic grant_spi;
    logic acc_end;

    always_comb begin
        spi_evt = (spi_addr_dv && !addr_dv_q && spi_rw) || (spi_rxdv && !rxdv_q && !spi_rw);
`ifdef LOC_FAIR_EN
        grant_spi = spi_pend && !(loc_req && last_spi);
`else
        grant_spi = spi_pend;
`endif
        acc_end = bus_ack || (timer == TMO_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr_dv_q <= 1'b0;
            rxdv_q    <= 1'b0;
            spi_pend  <= 1'b0;
            cap_rw    <= 1'b0;
            cap_addr  <= '0;
            cap_data  <= '0;
            timer     <= '0;
            spi_tx_d  <= '0;
            spi_tx_en <= 1'b0;
            loc_done  <= 1'b0;
            loc_rdata <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            tmo_err   <= 1'b0;
`ifdef LOC_FAIR_EN
            last_spi  <= 1'b0;
`endif
        end else begin
            addr_dv_q <= spi_addr_dv;
            rxdv_q    <= spi_rxdv;
            loc_done  <= 1'b0;
            tmo_err   <= 1'b0;
            if (!addr_dv_q) begin
                spi_tx_en <= 1'b0;
            end
            if (spi_evt) begin
                spi_pend <= 1'b1;
                cap_addr <= spi_addr;
                cap_rw   <= spi_rw;
                cap_data <= spi_rx_d;
            end
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (grant_spi) begin
                        state     <= SPI_ACC;
                        bus_req   <= 1'b1;
                        bus_we    <= !cap_rw;
                        bus_addr  <= cap_addr;
                        bus_wdata <= cap_data;
                        // an event landing on the grant edge stays pending
                        spi_pend  <= spi_evt;
`ifdef LOC_FAIR_EN
                        last_spi  <= 1'b1;
`endif
                    end else if (loc_req) begin
                        state     <= LOC_ACC;
                        bus_req   <= 1'b1;
                        bus_we    <= loc_we;
                        bus_addr  <= loc_addr;
                        bus_wdata <= loc_wdata;
`ifdef LOC_FAIR_EN
                        last_spi  <= 1'b0;
`endif
                    end
                end
                SPI_ACC, LOC_ACC: begin
                    if (acc_end) begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        timer   <= '0;
                        tmo_err <= !bus_ack;
                        if (state == SPI_ACC) begin
                            if (!bus_we) begin
                                spi_tx_en <= 1'b1;
                                spi_tx_d  <= bus_ack ? bus_rdata : '1;
                            end
                        end else begin
                            loc_done <= 1'b1;
                            if (!bus_ack) begin
                                loc_rdata <= '1;
                            end else if (!bus_we) begin
                                loc_rdata <= bus_rdata;
                            end
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/spi_reg_arbiter.md
# spi_reg_arbiter

Register-bus controller behind the SPI slave. It turns completed SPI header and payload events into single register-bus reads and writes, and returns read data to the slave's MISO shifter. It also shares the same register bus with one local (on-chip) requester. The block owns bus sequencing, arbitration and the ack timeout.

## Interface
Parameters:
- payload, 8: data width (SPI payload and register bus).
- addrsz, 7: register address width.
- TMO_CYC, 64: maximum clk cycles to wait for bus_ack before aborting; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous and active-high.
- spi_addr  in  addrsz  address from the SPI slave; stable while spi_addr_dv is high.
- spi_addr_dv  in  1  header complete; level, high until the SPI transaction ends.
- spi_rw  in  1  1 = SPI read, 0 = SPI write; valid while spi_addr_dv is high.
- spi_rx_d  in  payload  SPI write data; stable while spi_rxdv is high.
- spi_rxdv  in  1  write payload complete; level.
- spi_tx_d  out  payload  read data to the slave.
- spi_tx_en  out  1  the slave loads spi_tx_d on the rising edge of this signal and shifts while it is high.
- loc_req  in  1  local request; level, held with stable fields until loc_done.
- loc_we  in  1  local write (1) or read (0).
- loc_addr  in  addrsz  local address.
- loc_wdata  in  payload  local write data.
- loc_done  out  1  one-cycle completion pulse.
- loc_rdata  out  payload  local read data; valid with loc_done.
- bus_req  out  1  register bus request.
- bus_we  out  1  bus write strobe qualifier.
- bus_addr  out  addrsz  bus address.
- bus_wdata  out  payload  bus write data.
- bus_ack  in  1  one-cycle ack; bus_rdata is valid with it.
- bus_rdata  in  payload  bus read data.
- tmo_err  out  1  one-cycle pulse when a bus access times out.

## Operation
- Event detection uses registered copies of spi_addr_dv and spi_rxdv.
  - SPI read event: rising edge of spi_addr_dv while spi_rw=1.
  - SPI write event: rising edge of spi_rxdv while spi_rw=0.
  - A spi_addr_dv rise while spi_rw=0 is ignored.
- An SPI event sets spi_pend. The address, direction and data are captured in the same cycle. Only one SPI event can be pending at a time; a new event overwrites the captured values.
- FSM states: IDLE, SPI_ACC, LOC_ACC.
  - IDLE → SPI_ACC when spi_pend is set (subject to Configuration). This clears spi_pend.
  - IDLE → LOC_ACC when loc_req is high and SPI is not granted.
  - SPI_ACC / LOC_ACC → IDLE on bus_ack or on timeout.
- While in an ACC state:
  - bus_req=1, with bus_addr, bus_we and bus_wdata driven from the granted source.
  - A timer counts cycles from 0. When it reaches TMO_CYC-1 without bus_ack, the access aborts.
- SPI read completion:
  - On ack: spi_tx_d ← bus_rdata and spi_tx_en ← 1.
  - On timeout: spi_tx_d ← all-ones and spi_tx_en ← 1.
- spi_tx_en clears on the first cycle the registered spi_addr_dv is low. spi_tx_d holds its value.
- SPI write completion: there is no response to the slave.
- Local completion:
  - loc_done=1 for one cycle. loc_rdata ← bus_rdata on reads.
  - On timeout, loc_rdata ← all-ones and loc_done still pulses.
- On any timeout, tmo_err pulses for one cycle.
- An SPI event arriving during LOC_ACC is held in spi_pend and served after the local access completes. Local accesses are never preempted.
- Reset values of all outputs: 0 (spi_tx_d, spi_tx_en, loc_done, loc_rdata, bus_req, bus_we, bus_addr, bus_wdata, tmo_err). The FSM resets to IDLE, and spi_pend and the timer are cleared. Asserting reset mid-access drops bus_req asynchronously; the access is lost.

## Timing
- Event detect to bus_req high: 2 clk edges (edge-detect register, then grant).
- bus_req falls on the same clk edge that samples bus_ack=1. The next grant can occur on the following edge, so there is at least one idle cycle between accesses.
- SPI read latency: spi_addr_dv rise to spi_tx_en rise is 2 + (bus wait cycles + 1) edges.
  - System requirement: this must complete before the first SCLK falling edge of the data phase.
  - With 3-stage SCLK synchronisation in the slave, this budget is approximately half an SCLK period minus 3 clk.
- loc_done, tmo_err and the spi_tx_en rise are asserted on the edge that ends the access.
- Boundary: if bus_ack arrives in the same cycle the timer reaches TMO_CYC-1, the ack wins and no tmo_err is raised.
- Boundary: with TMO_CYC=1, a single wait cycle is allowed.

## Configuration
- LOC_FAIR_EN defined: alternating priority. A last_spi flag is set on each SPI grant and cleared on each local grant. If spi_pend and loc_req are both active in IDLE, local wins when last_spi=1; otherwise SPI wins.
- LOC_FAIR_EN undefined: fixed priority. SPI always wins simultaneous requests.

## Test plan
- SPI write, addr 0x15, data 0xA7, bus_ack 2 cycles after bus_req → one bus access with bus_we=1, bus_addr=0x15, bus_wdata=0xA7; spi_tx_en stays 0.
- SPI read, addr 0x03, bus_rdata=0x5C with 1-cycle ack → spi_tx_d=0x5C, spi_tx_en rises 4 edges after spi_addr_dv rise; spi_tx_en falls after spi_addr_dv falls.
- Local read at 0x7F with bus_ack never asserted, TMO_CYC=64 → tmo_err and loc_done both pulse on wait cycle 64; loc_rdata=0xFF; bus_req low on the following cycle.
- Local write in progress when an SPI read event arrives → local completes first (loc_done), then the SPI read is issued; no event is lost.
- Simultaneous SPI write and loc_req, repeated twice → without LOC_FAIR_EN the order is SPI, local, SPI, local (SPI first each time); with LOC_FAIR_EN, after an SPI grant the next simultaneous pair grants local first.
- Reset asserted while bus_req=1 → bus_req drops without waiting for a clock edge; all outputs are 0; the next event is serviced normally after reset is released.
